// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data memory access unit.
//   - MemWr code constants as produced by the main decoder
//   - MemtoReg value that marks a load
//   - FSM state enum and the internal operation enum
//   - decode_op(): maps the decoder outputs onto one operation
package data_mem_access_unit_pkg;

    localparam logic [2:0] MW_NONE = 3'b000;
    localparam logic [2:0] MW_SW   = 3'b001;
    localparam logic [2:0] MW_LB   = 3'b010;
    localparam logic [2:0] MW_LBU  = 3'b011;
    localparam logic [2:0] MW_SB   = 3'b101;

    localparam logic [1:0] MTR_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LW  = 3'd1,
        OP_LB  = 3'd2,
        OP_LBU = 3'd3,
        OP_SW  = 3'd4,
        OP_SB  = 3'd5
    } op_t;

    // LW is the only operation that needs MemtoReg: MemWr=000 alone is
    // also the "no memory access" code.
    function automatic op_t decode_op(input logic [2:0] memwr,
                                      input logic [1:0] memtoreg);
        op_t op;
        op = OP_NOP;
        case (memwr)
            MW_NONE: op = (memtoreg == MTR_LOAD) ? OP_LW : OP_NOP;
            MW_SW:   op = OP_SW;
            MW_LB:   op = OP_LB;
            MW_LBU:  op = OP_LBU;
            MW_SB:   op = OP_SB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_mem_access_unit_byte_lane_unit.sv
// Combinational byte-lane helper for the data memory access unit.
// Lanes are big-endian: lane 0 is word[31:24], lane 3 is word[7:0].
// Ports:
//   lane        in  2   byte offset within the word (addr[1:0])
//   word        in  32  word read from memory
//   byte_in     in  8   byte to insert for a byte store
//   sign_ext    in  1   1 = sign-extend the extracted lane, 0 = zero-extend
//   ext_data    out 32  extracted lane, extended to 32 bits
//   merged_word out 32  word with the selected lane replaced by byte_in
module byte_lane_unit (
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [7:0]  byte_in,
    input  logic        sign_ext,
    output logic [31:0] ext_data,
    output logic [31:0] merged_word
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = word[31:24];
        case (lane)
            2'd0: lane_byte = word[31:24];
            2'd1: lane_byte = word[23:16];
            2'd2: lane_byte = word[15:8];
            2'd3: lane_byte = word[7:0];
            default: lane_byte = word[31:24];
        endcase
    end

    assign ext_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};

    // Byte slice gi (bits gi*8+7..gi*8) is lane 3-gi in big-endian order.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] SEL = 2'(3 - gi);
            assign merged_word[gi*8 +: 8] = (lane == SEL) ? byte_in : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_access_unit.sv
// Data memory access unit: executes the memory operation decoded by the
// main decoder as a req/ack transaction against a word-only memory.
// Byte loads extract a lane, byte stores run as read-modify-write.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 launch an access (sampled only in IDLE)
//   memwr, memtoreg       decoder memory control
//   addr, wdata           effective byte address, store data
//   busy, done, err       stall request, completion pulse, error pulse
//   rdata                 load result, held until the next load completes
//   mem_req, mem_we       memory request and direction
//   mem_addr, mem_wdata   word address, write word
//   mem_rdata, mem_ack    read word, memory accept/return
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        memwr,
    input  logic [1:0]        memtoreg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_reg, state_next;
    op_t               op_reg, op_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    // Store word for SW; for SB it first holds wdata (only [7:0] matters)
    // and is overwritten with the merged word at the read ack.
    logic [31:0]       word_reg, word_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [31:0]       ext_data;
    logic [31:0]       merged_word;
    op_t               start_op;

    byte_lane_unit u_lane (
        .lane        (addr_reg[1:0]),
        .word        (mem_rdata),
        .byte_in     (word_reg[7:0]),
        .sign_ext    (op_reg == OP_LB),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

    assign start_op = decode_op(memwr, memtoreg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= OP_NOP;
            addr_reg  <= '0;
            word_reg  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            word_reg  <= word_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        word_next  = word_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next   = start_op;
                    addr_next = addr;
                    word_next = wdata;
                    err_next  = 1'b0;
                    cnt_next  = '0;
                    case (start_op)
                        OP_LW: begin
                            if (addr[1:0] != 2'b00) begin
                                state_next = DONE;
                                err_next   = 1'b1;
                            end else begin
                                state_next = RD;
                            end
                        end
                        OP_SW: begin
                            if (addr[1:0] != 2'b00) begin
                                state_next = DONE;
                                err_next   = 1'b1;
                            end else begin
                                state_next = WR;
                            end
                        end
                        OP_LB, OP_LBU, OP_SB: state_next = RD;
                        default:              state_next = DONE;
                    endcase
                end
            end

            RD: begin
                // An ack on the last counted cycle still completes normally.
                if (mem_ack) begin
                    cnt_next = '0;
                    if (op_reg == OP_SB) begin
                        word_next  = merged_word;
                        state_next = WR;
                    end else begin
                        rdata_next = (op_reg == OP_LW) ? mem_rdata : ext_data;
                        state_next = DONE;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            WR: begin
                if (mem_ack) begin
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == RD) || (state_reg == WR);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == DONE) && err_reg;
    assign rdata     = rdata_reg;
    assign mem_req   = busy;
    assign mem_we    = (state_reg == WR);
    assign mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_wdata = word_reg;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  memwr;
    logic [1:0]  memtoreg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last do_access call
    int          r_done_cyc;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_reqs;
    int          r_nrd;
    int          r_nwr;
    int          r_busy;
    logic [31:0] r_rd_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_done2;

    data_mem_access_unit #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .memwr     (memwr),
        .memtoreg  (memtoreg),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one access and plays the memory: ack after `waits` idle
    // request cycles in each phase, returning `word` on reads. Cycle 1 is
    // the cycle after the start edge. Bounded at 100 cycles.
    task automatic do_access(input logic [2:0] mw, input logic [1:0] mtr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] word, input int waits);
        int wcnt;
        r_done_cyc = -1; r_err = 1'b0; r_rdata = '0; r_reqs = 0;
        r_nrd = 0; r_nwr = 0; r_busy = 0;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
        @(negedge clk);
        memwr = mw; memtoreg = mtr; addr = a; wdata = wd;
        start = 1'b1; mem_ack = 1'b0;
        @(posedge clk);
        wcnt = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (busy) r_busy++;
            if (done) begin
                r_done_cyc = cyc;
                r_err = err;
                r_rdata = rdata;
                break;
            end
            if (mem_req) begin
                r_reqs++;
                if (wcnt >= waits) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                    if (mem_we) begin
                        r_nwr++;
                        r_wr_addr = mem_addr;
                        r_wr_data = mem_wdata;
                    end else begin
                        r_nrd++;
                        r_rd_addr = mem_addr;
                        mem_rdata = word;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
        @(negedge clk);
        r_done2 = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; memwr = '0; memtoreg = '0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset: busy=%b done=%b err=%b req=%b we=%b addr=%h wdata=%h rdata=%h",
                 busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, rdata);
        n_cmp++; if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, err, mem_req, mem_we});
        end
        n_cmp++; if (rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata got=%h exp=00000000", rdata);
        end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        do_access(3'b000, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        $display("LW 0x10: done@%0d rdata=%h err=%b reads=%0d", r_done_cyc, r_rdata, r_err, r_nrd);
        n_cmp++; if (r_done_cyc !== 2) begin
            n_err++; $display("FAIL lw_latency got=%0d exp=2", r_done_cyc);
        end
        n_cmp++; if (r_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lw_rdata got=%h exp=deadbeef", r_rdata);
        end
        n_cmp++; if (r_err !== 1'b0) begin
            n_err++; $display("FAIL lw_err got=%b exp=0", r_err);
        end
        n_cmp++; if (r_rd_addr !== 32'h10 || r_nrd != 1 || r_nwr != 0) begin
            n_err++; $display("FAIL lw_bus got addr=%h rd=%0d wr=%0d exp addr=10 rd=1 wr=0", r_rd_addr, r_nrd, r_nwr);
        end
        n_cmp++; if (r_done2 !== 1'b0) begin
            n_err++; $display("FAIL lw_done_pulse got=%b exp=0", r_done2);
        end
        n_cmp++; if (r_busy != 1) begin
            n_err++; $display("FAIL lw_busy_cycles got=%0d exp=1", r_busy);
        end
    endtask

    task automatic test_lb_lbu();
        do_access(3'b010, 2'b01, 32'h11, 32'h0, 32'h12F45678, 0);
        $display("LB 0x11: done@%0d rdata=%h addr=%h", r_done_cyc, r_rdata, r_rd_addr);
        n_cmp++; if (r_rdata !== 32'hFFFFFFF4 || r_done_cyc !== 2) begin
            n_err++; $display("FAIL lb_rdata got=%h@%0d exp=fffffff4@2", r_rdata, r_done_cyc);
        end
        n_cmp++; if (r_rd_addr !== 32'h10) begin
            n_err++; $display("FAIL lb_word_addr got=%h exp=00000010", r_rd_addr);
        end
        do_access(3'b011, 2'b01, 32'h11, 32'h0, 32'h12F45678, 0);
        $display("LBU 0x11: done@%0d rdata=%h", r_done_cyc, r_rdata);
        n_cmp++; if (r_rdata !== 32'h000000F4 || r_done_cyc !== 2) begin
            n_err++; $display("FAIL lbu_rdata got=%h@%0d exp=000000f4@2", r_rdata, r_done_cyc);
        end
        // Lane 3 with a positive byte, lane 0 with a negative one
        do_access(3'b010, 2'b01, 32'h17, 32'h0, 32'h8000007F, 0);
        $display("LB 0x17: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 32'h0000007F) begin
            n_err++; $display("FAIL lb_lane3 got=%h exp=0000007f", r_rdata);
        end
        do_access(3'b010, 2'b01, 32'h14, 32'h0, 32'h8000007F, 0);
        $display("LB 0x14: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 32'hFFFFFF80) begin
            n_err++; $display("FAIL lb_lane0 got=%h exp=ffffff80", r_rdata);
        end
        do_access(3'b011, 2'b01, 32'h16, 32'h0, 32'hFFFFF4FF, 0);
        $display("LBU 0x16: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 32'h000000F4) begin
            n_err++; $display("FAIL lbu_lane2 got=%h exp=000000f4", r_rdata);
        end
    endtask

    task automatic test_sb();
        do_access(3'b101, 2'b00, 32'h22, 32'h000000AB, 32'h11223344, 0);
        $display("SB 0x22: done@%0d rd=%0d wr=%0d wr_addr=%h wr_data=%h", r_done_cyc, r_nrd, r_nwr, r_wr_addr, r_wr_data);
        n_cmp++; if (r_done_cyc !== 3) begin
            n_err++; $display("FAIL sb_latency got=%0d exp=3", r_done_cyc);
        end
        n_cmp++; if (r_wr_data !== 32'h1122AB44) begin
            n_err++; $display("FAIL sb_merge got=%h exp=1122ab44", r_wr_data);
        end
        n_cmp++; if (r_wr_addr !== 32'h20 || r_nrd != 1 || r_nwr != 1) begin
            n_err++; $display("FAIL sb_bus got addr=%h rd=%0d wr=%0d exp addr=20 rd=1 wr=1", r_wr_addr, r_nrd, r_nwr);
        end
        n_cmp++; if (r_rdata !== 32'h000000F4 || r_err !== 1'b0) begin
            n_err++; $display("FAIL sb_rdata_hold got=%h err=%b exp=000000f4 err=0", r_rdata, r_err);
        end
        n_cmp++; if (r_busy != 2) begin
            n_err++; $display("FAIL sb_busy_cycles got=%0d exp=2", r_busy);
        end
    endtask

    task automatic test_sw();
        do_access(3'b001, 2'b00, 32'h13, 32'hCAFEF00D, 32'h0, 0);
        $display("SW 0x13 (misaligned): done@%0d err=%b reqs=%0d", r_done_cyc, r_err, r_reqs);
        n_cmp++; if (r_done_cyc !== 1 || r_err !== 1'b1) begin
            n_err++; $display("FAIL sw_misaligned got done@%0d err=%b exp done@1 err=1", r_done_cyc, r_err);
        end
        n_cmp++; if (r_reqs != 0 || r_busy != 0) begin
            n_err++; $display("FAIL sw_misaligned_noreq got reqs=%0d busy=%0d exp 0 0", r_reqs, r_busy);
        end
        do_access(3'b000, 2'b01, 32'h12, 32'h0, 32'h55555555, 0);
        $display("LW 0x12 (misaligned): done@%0d err=%b rdata=%h", r_done_cyc, r_err, r_rdata);
        n_cmp++; if (r_done_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'h000000F4 || r_reqs != 0) begin
            n_err++; $display("FAIL lw_misaligned got done@%0d err=%b rdata=%h reqs=%0d exp done@1 err=1 rdata=000000f4 reqs=0",
                              r_done_cyc, r_err, r_rdata, r_reqs);
        end
        do_access(3'b001, 2'b00, 32'h40, 32'hCAFEF00D, 32'h0, 2);
        $display("SW 0x40 (2 waits): done@%0d wr_addr=%h wr_data=%h", r_done_cyc, r_wr_addr, r_wr_data);
        n_cmp++; if (r_done_cyc !== 4 || r_wr_data !== 32'hCAFEF00D || r_wr_addr !== 32'h40 || r_nrd != 0) begin
            n_err++; $display("FAIL sw_write got done@%0d data=%h addr=%h rd=%0d exp done@4 data=cafef00d addr=40 rd=0",
                              r_done_cyc, r_wr_data, r_wr_addr, r_nrd);
        end
    endtask

    task automatic test_nop();
        do_access(3'b111, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        $display("NOP: done@%0d err=%b reqs=%0d busy=%0d", r_done_cyc, r_err, r_reqs, r_busy);
        n_cmp++; if (r_done_cyc !== 1 || r_err !== 1'b0 || r_reqs != 0 || r_busy != 0) begin
            n_err++; $display("FAIL nop got done@%0d err=%b reqs=%0d busy=%0d exp done@1 err=0 reqs=0 busy=0",
                              r_done_cyc, r_err, r_reqs, r_busy);
        end
    endtask

    task automatic test_timeout();
        do_access(3'b000, 2'b01, 32'h30, 32'h0, 32'h99999999, 1000);
        $display("LW 0x30 no ack: done@%0d err=%b reqs=%0d rdata=%h", r_done_cyc, r_err, r_reqs, r_rdata);
        n_cmp++; if (r_reqs != 16 || r_done_cyc !== 17) begin
            n_err++; $display("FAIL timeout_len got reqs=%0d done@%0d exp reqs=16 done@17", r_reqs, r_done_cyc);
        end
        n_cmp++; if (r_err !== 1'b1 || r_rdata !== 32'h000000F4) begin
            n_err++; $display("FAIL timeout_result got err=%b rdata=%h exp err=1 rdata=000000f4", r_err, r_rdata);
        end
        // Ack on the 16th request cycle wins over the timeout
        do_access(3'b000, 2'b01, 32'h30, 32'h0, 32'h99999999, 15);
        $display("LW 0x30 ack on last count: done@%0d err=%b rdata=%h", r_done_cyc, r_err, r_rdata);
        n_cmp++; if (r_err !== 1'b0 || r_rdata !== 32'h99999999 || r_done_cyc !== 17) begin
            n_err++; $display("FAIL ack_wins got err=%b rdata=%h done@%0d exp err=0 rdata=99999999 done@17",
                              r_err, r_rdata, r_done_cyc);
        end
        // SB timing out in its read phase issues no write
        do_access(3'b101, 2'b00, 32'h21, 32'hAB, 32'h0, 1000);
        $display("SB 0x21 no ack: done@%0d err=%b writes=%0d", r_done_cyc, r_err, r_nwr);
        n_cmp++; if (r_err !== 1'b1 || r_nwr != 0 || r_done_cyc !== 17) begin
            n_err++; $display("FAIL sb_timeout got err=%b wr=%0d done@%0d exp err=1 wr=0 done@17", r_err, r_nwr, r_done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        memwr = 3'b101; memtoreg = 2'b00; addr = 32'h22; wdata = 32'hAB; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ack = (cyc == 4);
            mem_rdata = 32'h11223344;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_in_write got req=%b we=%b exp 1 1", mem_req, mem_we);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("SB reset during write: req=%b busy=%b done=%b rdata=%h", mem_req, busy, done, rdata);
        n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_outputs got req=%b busy=%b done=%b rdata=%h exp 0 0 0 00000000",
                              mem_req, busy, done, rdata);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || mem_req) done_seen++;
        end
        n_cmp++; if (done_seen != 0) begin
            n_err++; $display("FAIL rst_mid_quiet got=%0d exp=0", done_seen);
        end
        do_access(3'b000, 2'b01, 32'h50, 32'h0, 32'h0BADF00D, 0);
        $display("LW 0x50 after reset: done@%0d rdata=%h err=%b", r_done_cyc, r_rdata, r_err);
        n_cmp++; if (r_done_cyc !== 2 || r_rdata !== 32'h0BADF00D || r_err !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_recover got done@%0d rdata=%h err=%b exp done@2 rdata=0badf00d err=0",
                              r_done_cyc, r_rdata, r_err);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sb();
        test_sw();
        test_nop();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
